decode_skid: RTL and testbench

- IF/ID boundary stage: accepts fetched instruction words and PCs from the fetch unit over a valid/ready handshake.
- Buffers them in a 2-entry skid buffer and presents one held instruction per cycle to decode.
- Slices out the opcode, sign-extension vector and register/function fields that the immediate generator and register file consume.
- Supports pipeline flush on redirect (branch/jump taken, trap).

---
 rtl/decode_skid_pkg.sv | 23 ++
 rtl/decode_skid_instr_fields.sv | 39 +++
 rtl/decode_skid.sv | 86 ++++++++
 tb/tb_decode_skid.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_skid_pkg.sv
// Shared constants for the IF/ID boundary: RV32I base opcodes (instr[6:2]) and the canonical NOP.
package decode_skid_pkg;

    localparam int unsigned XLEN_RV32 = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [4:0] {
        OpLoad   = 5'b00000,
        OpFence  = 5'b00011,
        OpArithI = 5'b00100,
        OpAuipc  = 5'b00101,
        OpStore  = 5'b01000,
        OpArithR = 5'b01100,
        OpLui    = 5'b01101,
        OpBranch = 5'b11000,
        OpJalr   = 5'b11001,
        OpJal    = 5'b11011,
        OpSystem = 5'b11100
    } opcode_e;

endpackage

// File: rtl/decode_skid_instr_fields.sv
// Combinational RV32I field slicer: opcode, sign-extension vector, register/function fields and
// an illegal flag for words outside the supported base opcode set.
module decode_skid_instr_fields
    import decode_skid_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output logic [4:0]  opcode,
    output logic [21:0] signExt,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        illegal
);

    logic known_op;

    assign opcode  = instr[6:2];
    assign signExt = {22{instr[31]}};
    assign rd      = instr[11:7];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];

    always_comb begin
        known_op = 1'b0;
        case (opcode)
            OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad,
            OpStore, OpArithI, OpArithR, OpFence, OpSystem: known_op = 1'b1;
            default: known_op = 1'b0;
        endcase
    end

    assign illegal = valid && ((instr[1:0] != 2'b11) || !known_op);

endmodule

// File: rtl/decode_skid.sv
// IF/ID boundary stage: 2-entry skid buffer between fetch and decode with flush, presenting
// the held instruction and its sliced fields.
module decode_skid
    import decode_skid_pkg::*;
#(
    parameter int unsigned     XLEN = XLEN_RV32,
    parameter logic [XLEN-1:0] NOP  = NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] inInstr,
    input  logic [XLEN-1:0] inPc,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outInstr,
    output logic [XLEN-1:0] outPc,
    output logic [4:0]      opcode,
    output logic [21:0]     signExt,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            illegal
);

    logic            main_valid_q, skid_valid_q;
    logic [XLEN-1:0] main_instr_q, main_pc_q;
    logic [XLEN-1:0] skid_instr_q, skid_pc_q;
    logic            in_fire;
    logic            main_free;

    // Ready depends only on state, so fetch never sees a path from outReady.
    assign inReady   = !skid_valid_q;
    assign in_fire   = inValid && inReady;
    assign main_free = !main_valid_q || outReady;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_instr_q <= NOP;
            main_pc_q    <= '0;
            skid_instr_q <= NOP;
            skid_pc_q    <= '0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_valid_q <= 1'b1;
                main_instr_q <= skid_instr_q;
                main_pc_q    <= skid_pc_q;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                main_valid_q <= 1'b1;
                main_instr_q <= inInstr;
                main_pc_q    <= inPc;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_q <= 1'b1;
            skid_instr_q <= inInstr;
            skid_pc_q    <= inPc;
        end
    end

    assign outValid = main_valid_q;
    assign outInstr = main_valid_q ? main_instr_q : NOP;
    assign outPc    = main_valid_q ? main_pc_q : '0;

    decode_skid_instr_fields u_fields (
        .instr   (outInstr),
        .valid   (main_valid_q),
        .opcode  (opcode),
        .signExt (signExt),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct3  (funct3),
        .funct7  (funct7),
        .illegal (illegal)
    );

endmodule

// File: tb/tb_decode_skid.sv
// Bench for decode_skid: a 2-deep FIFO reference model checked every cycle, plus literal pins.
module tb_decode_skid;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, outReady;
    logic [31:0] inInstr, inPc;
    logic        inReady, outValid, illegal;
    logic [31:0] outInstr, outPc;
    logic [4:0]  opcode, rd, rs1, rs2;
    logic [21:0] signExt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];

    always #5 clk = ~clk;

    decode_skid dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (inValid),
        .inReady  (inReady),
        .inInstr  (inInstr),
        .inPc     (inPc),
        .outValid (outValid),
        .outReady (outReady),
        .outInstr (outInstr),
        .outPc    (outPc),
        .opcode   (opcode),
        .signExt  (signExt),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .illegal  (illegal)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_op(input logic [4:0] op);
        logic [4:0] ops [11] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                                 5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100};
        for (int i = 0; i < 11; i++)
            if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Full output comparison against the FIFO model.
    task automatic compare_all();
        logic        ev;
        logic [31:0] ei, ep;
        ev = (q_instr.size() > 0);
        ei = ev ? q_instr[0] : 32'h0000_0013;
        ep = ev ? q_pc[0] : 32'h0;
        chk("outValid", 64'(outValid), 64'(ev));
        chk("inReady",  64'(inReady),  64'(q_instr.size() < 2));
        chk("outInstr", 64'(outInstr), 64'(ei));
        chk("outPc",    64'(outPc),    64'(ep));
        chk("opcode",   64'(opcode),   64'(ei[6:2]));
        chk("signExt",  64'(signExt),  ei[31] ? 64'h3F_FFFF : 64'h0);
        chk("rd",       64'(rd),       64'(ei[11:7]));
        chk("rs1",      64'(rs1),      64'(ei[19:15]));
        chk("rs2",      64'(rs2),      64'(ei[24:20]));
        chk("funct3",   64'(funct3),   64'(ei[14:12]));
        chk("funct7",   64'(funct7),   64'(ei[31:25]));
        chk("illegal",  64'(illegal),  64'(ev && (ei[1:0] != 2'b11 || !legal_op(ei[6:2]))));
    endtask

    // One clock: model updates from the inputs seen at the edge, then outputs are compared.
    task automatic cycle();
        bit acc, con;
        @(posedge clk);
        acc = inValid && (q_instr.size() < 2);
        con = outReady && (q_instr.size() > 0);
        if (rst || flush) begin
            q_instr.delete();
            q_pc.delete();
        end else begin
            if (con) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (acc) begin
                q_instr.push_back(inInstr);
                q_pc.push_back(inPc);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        inValid = v;
        inInstr = instr;
        inPc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; outReady = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        cycle();
        cycle();
        chk("rst_outValid", 64'(outValid), 64'd0);
        chk("rst_inReady",  64'(inReady),  64'd1);
        chk("rst_outInstr", 64'(outInstr), 64'h13);
        chk("rst_opcode",   64'(opcode),   64'b00100);
        chk("rst_signExt",  64'(signExt),  64'd0);
        chk("rst_illegal",  64'(illegal),  64'd0);
        rst = 1'b0;
        cycle();

        // Streaming
        outReady = 1'b1;
        drive(1'b1, 32'h0050_0093, 32'h0);
        cycle();
        chk("stream_w0", 64'(outInstr), 64'h0050_0093);
        drive(1'b1, 32'hFFF0_0113, 32'h4);
        cycle();
        chk("stream_w1", 64'(outInstr), 64'hFFF0_0113);
        chk("stream_rd", 64'(rd), 64'd2);
        chk("stream_sx", 64'(signExt), 64'h3F_FFFF);
        chk("stream_op", 64'(opcode), 64'b00100);
        drive(1'b1, 32'h00C0_00EF, 32'h8);
        cycle();
        chk("stream_pc2", 64'(outPc), 64'h8);
        drive(1'b0, 32'h0, 32'h0);
        cycle();

        // Backpressure
        outReady = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'h10);
        cycle();
        drive(1'b1, 32'h0020_0113, 32'h14);
        cycle();
        chk("bp_full_inReady", 64'(inReady), 64'd0);
        drive(1'b1, 32'h0030_0193, 32'h18);
        cycle();
        cycle();
        chk("bp_hold_head", 64'(outInstr), 64'h0010_0093);
        outReady = 1'b1;
        cycle();
        chk("bp_drain2", 64'(outInstr), 64'h0020_0113);
        cycle();
        chk("bp_drain3", 64'(outInstr), 64'h0030_0193);
        drive(1'b0, 32'h0, 32'h0);
        cycle();
        cycle();

        // Flush with both entries full and a word offered
        outReady = 1'b0;
        drive(1'b1, 32'h0040_0213, 32'h20);
        cycle();
        drive(1'b1, 32'h0050_0293, 32'h24);
        cycle();
        drive(1'b1, 32'h0060_0313, 32'h28);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_outValid", 64'(outValid), 64'd0);
        chk("flush_inReady",  64'(inReady),  64'd1);
        chk("flush_outInstr", 64'(outInstr), 64'h13);
        outReady = 1'b1;
        cycle();
        cycle();

        // Illegal detection
        drive(1'b1, 32'h0000_0000, 32'h30);
        cycle();
        chk("ill_zero", 64'(illegal), 64'd1);
        drive(1'b1, 32'h0000_007B, 32'h34);
        cycle();
        chk("ill_op11110", 64'(illegal), 64'd1);
        drive(1'b1, 32'h0000_0073, 32'h38);
        cycle();
        chk("ecall_legal", 64'(illegal), 64'd0);
        chk("ecall_op", 64'(opcode), 64'b11100);
        drive(1'b0, 32'h0, 32'h0);
        cycle();
        chk("idle_illegal", 64'(illegal), 64'd0);

        // Reset while stalled with both entries full
        outReady = 1'b0;
        drive(1'b1, 32'h0070_0393, 32'h40);
        cycle();
        drive(1'b1, 32'h0080_0413, 32'h44);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstmid_outValid", 64'(outValid), 64'd0);
        chk("rstmid_inReady",  64'(inReady),  64'd1);
        drive(1'b1, 32'h1234_50B7, 32'h100);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        chk("lui_instr", 64'(outInstr), 64'h1234_50B7);
        chk("lui_rd",    64'(rd),       64'd1);
        chk("lui_op",    64'(opcode),   64'b01101);
        outReady = 1'b1;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
